// File: rtl/ff_bank_pkg.sv
// Shared mode encodings for the multi-mode flip-flop bank.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } ff_mode_e;

endpackage

// File: rtl/multi_mode_ff_bank_if.sv
// Control/data bundle between a driver and the flip-flop bank.
interface multi_mode_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] illegal;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, mode, a, b, load, load_val, err_clr,
    input  q, qb, illegal, err_cnt
  );

  modport slave (
    input  en, mode, a, b, load, load_val, err_clr,
    output q, qb, illegal, err_cnt
  );
endinterface

// File: rtl/ff_bit_next.sv
// Next-state logic for one flip-flop bit in SR/JK/D/T mode, plus S=R=1 detect.
module ff_bit_next
  import ff_bank_pkg::*;
(
  input  logic     q,
  input  logic     a,
  input  logic     b,
  input  ff_mode_e mode,
  output logic     q_next,
  output logic     illegal_det
);

  always_comb begin
    q_next      = q;
    illegal_det = 1'b0;
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b10:   q_next = 1'b1;
          2'b01:   q_next = 1'b0;
          2'b11:   illegal_det = 1'b1;
          default: q_next = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   q_next = 1'b1;
          2'b01:   q_next = 1'b0;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = a;
      MODE_T:  q_next = a ? ~q : q;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit flip-flop bank with runtime SR/JK/D/T mode, parallel load,
// sticky illegal-SR flags and a saturating illegal-event counter.
module multi_mode_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit NEG_EDGE = 1'b1,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  multi_mode_ff_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] ill_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] bit_nxt;
  logic [WIDTH-1:0] bit_det;
  logic [WIDTH-1:0] det_eff;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] ill_base;
  logic [WIDTH-1:0] ill_nxt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_bit_next u_bit (
      .q           (q_r[i]),
      .a           (bus.a[i]),
      .b           (bus.b[i]),
      .mode        (ff_mode_e'(bus.mode)),
      .q_next      (bit_nxt[i]),
      .illegal_det (bit_det[i])
    );
  end

  // Detections only count on a plain enabled update; a load masks them.
  always_comb begin
    q_nxt   = q_r;
    det_eff = '0;
    if (bus.load) begin
      q_nxt = bus.load_val;
    end else if (bus.en) begin
      q_nxt   = bit_nxt;
      det_eff = bit_det;
    end
  end

  // Clear happens before this edge's detections are folded in.
  always_comb begin
    ill_base = bus.err_clr ? '0 : ill_r;
    cnt_base = bus.err_clr ? '0 : cnt_r;
    ill_nxt  = ill_base | det_eff;
    cnt_nxt  = cnt_base;
    if ((|det_eff) && (cnt_base != CNT_MAX)) begin
      cnt_nxt = cnt_base + CNT_W'(1);
    end
  end

  if (NEG_EDGE) begin : g_neg
    always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
        q_r   <= '0;
        ill_r <= '0;
        cnt_r <= '0;
      end else begin
        q_r   <= q_nxt;
        ill_r <= ill_nxt;
        cnt_r <= cnt_nxt;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q_r   <= '0;
        ill_r <= '0;
        cnt_r <= '0;
      end else begin
        q_r   <= q_nxt;
        ill_r <= ill_nxt;
        cnt_r <= cnt_nxt;
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.qb      = ~q_r;
  assign bus.illegal = ill_r;
  assign bus.err_cnt = cnt_r;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Randomized, model-checked bench for multi_mode_ff_bank (rising- and falling-edge builds).
module tb_multi_mode_ff_bank;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  // Reference state for the rising-edge instance.
  logic [7:0] m_q;
  logic [7:0] m_ill;
  int         m_cnt;

  multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(4)) bus_p ();
  multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(4)) bus_n ();

  multi_mode_ff_bank #(.WIDTH(8), .NEG_EDGE(1'b0), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_p)
  );

  multi_mode_ff_bank #(.WIDTH(8), .NEG_EDGE(1'b1), .CNT_W(4)) dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1, "watchdog");
  end

  // Spec-level behaviour of one active edge, bit by bit.
  task automatic model_edge();
    logic [7:0] nq;
    logic [7:0] hit;
    nq  = m_q;
    hit = '0;
    if (bus_p.load) begin
      nq = bus_p.load_val;
    end else if (bus_p.en) begin
      for (int i = 0; i < 8; i++) begin
        case (bus_p.mode)
          2'd0: begin
            if (bus_p.a[i] && !bus_p.b[i]) nq[i] = 1'b1;
            else if (!bus_p.a[i] && bus_p.b[i]) nq[i] = 1'b0;
            else if (bus_p.a[i] && bus_p.b[i]) hit[i] = 1'b1;
          end
          2'd1: begin
            if (bus_p.a[i] && !bus_p.b[i]) nq[i] = 1'b1;
            else if (!bus_p.a[i] && bus_p.b[i]) nq[i] = 1'b0;
            else if (bus_p.a[i] && bus_p.b[i]) nq[i] = !m_q[i];
          end
          2'd2: nq[i] = bus_p.a[i];
          default: if (bus_p.a[i]) nq[i] = !m_q[i];
        endcase
      end
    end
    if (bus_p.err_clr) begin
      m_ill = '0;
      m_cnt = 0;
    end
    m_ill = m_ill | hit;
    if (hit != 0 && m_cnt < 15) m_cnt = m_cnt + 1;
    m_q = nq;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] mode, input logic [7:0] a,
                       input logic [7:0] b, input logic load, input logic [7:0] lv,
                       input logic clr);
    bus_p.en       = en;
    bus_p.mode     = mode;
    bus_p.a        = a;
    bus_p.b        = b;
    bus_p.load     = load;
    bus_p.load_val = lv;
    bus_p.err_clr  = clr;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b0);
    step();
    n_tests++;
    if (bus_p.q !== 8'hA5) begin
      n_fail++;
      $display("FAIL reset_preload: q=%h required=%h", bus_p.q, 8'hA5);
    end
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    m_q = '0; m_ill = '0; m_cnt = 0;
    n_tests++;
    if (bus_p.q !== 8'h00 || bus_p.qb !== 8'hFF || bus_p.illegal !== 8'h00 || bus_p.err_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_async: q=%h qb=%h ill=%h cnt=%0d required=00 FF 00 0",
               bus_p.q, bus_p.qb, bus_p.illegal, bus_p.err_cnt);
    end
    n_tests++;
    if (bus_n.q !== 8'h00 || bus_n.qb !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_async_neg: q=%h qb=%h required=00 FF", bus_n.q, bus_n.qb);
    end
    reset = 1'b0;
  endtask

  task automatic test_sr();
    drive(1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0);
    step();
    n_tests++;
    if (bus_p.q !== 8'h0F) begin
      n_fail++;
      $display("FAIL sr_set_reset: q=%h required=%h", bus_p.q, 8'h0F);
    end
    drive(1'b1, 2'd0, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
    step();
    n_tests++;
    if (bus_p.q !== 8'h0F || bus_p.illegal !== 8'h01 || bus_p.err_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL sr_illegal: q=%h ill=%h cnt=%0d required=0F 01 1",
               bus_p.q, bus_p.illegal, bus_p.err_cnt);
    end
  endtask

  task automatic test_toggle();
    logic [7:0] exp_seq [2];
    exp_seq[0] = 8'h55;
    exp_seq[1] = 8'hAA;
    for (int m = 1; m <= 3; m += 2) begin
      drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'hAA, 1'b0);
      step();
      for (int k = 0; k < 2; k++) begin
        drive(1'b1, 2'(m), 8'hFF, (m == 1) ? 8'hFF : 8'h00, 1'b0, 8'h00, 1'b0);
        step();
        n_tests++;
        if (bus_p.q !== exp_seq[k]) begin
          n_fail++;
          $display("FAIL toggle_mode%0d_edge%0d: q=%h required=%h", m, k, bus_p.q, exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] cnt0;
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    step();
    cnt0 = bus_p.err_cnt;
    drive(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b1, 8'h3C, 1'b0);
    step();
    n_tests++;
    if (bus_p.q !== 8'h3C || bus_p.illegal !== 8'h00 || bus_p.err_cnt !== 4'd0 || cnt0 !== 4'd0) begin
      n_fail++;
      $display("FAIL priority_load: q=%h ill=%h cnt=%0d required=3C 00 0",
               bus_p.q, bus_p.illegal, bus_p.err_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b0, 8'($urandom), 1'b0);
      step();
      n_tests++;
      if (bus_p.q !== 8'h3C || bus_p.illegal !== 8'h00) begin
        n_fail++;
        $display("FAIL priority_hold%0d: q=%h ill=%h required=3C 00", k, bus_p.q, bus_p.illegal);
      end
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    step();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 2'd0, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
      step();
      if (k == 14 || k == 19) begin
        n_tests++;
        if (bus_p.err_cnt !== 4'd15) begin
          n_fail++;
          $display("FAIL saturate_edge%0d: cnt=%0d required=15", k, bus_p.err_cnt);
        end
      end
    end
    drive(1'b1, 2'd0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    step();
    n_tests++;
    if (bus_p.illegal !== 8'h80 || bus_p.err_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL clear_with_event: ill=%h cnt=%0d required=80 1", bus_p.illegal, bus_p.err_cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 9) == 0));
      step();
      n_tests++;
      if (bus_p.q !== m_q || bus_p.qb !== ~m_q || bus_p.illegal !== m_ill ||
          bus_p.err_cnt !== 4'(m_cnt)) begin
        n_fail++;
        $display("FAIL random%0d: q=%h qb=%h ill=%h cnt=%0d required=%h %h %h %0d",
                 k, bus_p.q, bus_p.qb, bus_p.illegal, bus_p.err_cnt, m_q, ~m_q, m_ill, m_cnt);
      end
    end
  endtask

  task automatic test_edge_select();
    logic [7:0] old_q;
    if (m_q == 8'h5A) begin
      drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b0);
      step();
    end
    old_q = m_q;
    drive(1'b1, 2'd2, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    n_tests++;
    if (bus_p.q !== old_q) begin
      n_fail++;
      $display("FAIL edge_pos_on_fall: q=%h required=%h", bus_p.q, old_q);
    end
    step();
    n_tests++;
    if (bus_p.q !== 8'h5A) begin
      n_fail++;
      $display("FAIL edge_pos_on_rise: q=%h required=%h", bus_p.q, 8'h5A);
    end
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    @(negedge clk);
    #1;
    bus_n.en   = 1'b1;
    bus_n.mode = 2'd2;
    bus_n.a    = 8'h5A;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus_n.q !== 8'h00) begin
      n_fail++;
      $display("FAIL edge_neg_on_rise: q=%h required=%h", bus_n.q, 8'h00);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (bus_n.q !== 8'h5A || bus_n.qb !== 8'hA5) begin
      n_fail++;
      $display("FAIL edge_neg_on_fall: q=%h qb=%h required=5A A5", bus_n.q, bus_n.qb);
    end
    bus_n.en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_q = '0; m_ill = '0; m_cnt = 0;
    reset = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    bus_n.en       = 1'b0;
    bus_n.mode     = 2'd0;
    bus_n.a        = 8'h00;
    bus_n.b        = 8'h00;
    bus_n.load     = 1'b0;
    bus_n.load_val = 8'h00;
    bus_n.err_clr  = 1'b0;
    #12;
    reset = 1'b0;

    test_reset();
    test_sr();
    test_toggle();
    test_priority();
    test_saturation();
    test_random();
    test_edge_select();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
